branch_sequencer: RTL
=====================

// Module: branch_sequencer
// PURPOSE
//  Instruction sequencer for the 16-bit CPU. Owns the program counter, fetches one instruction
//  word per step over a req/ack handshake, and drives the condition code to the comparator.
//  For branches it samples the comparator jump flag and selects the target or PC+1.
//  It also stalls on multi-cycle datapath ops and handles start/halt.
// PARAMETERS
//  ADDR_W    16       width of PC / instruction address
//  RESET_PC  16'h0000 PC value after reset
// PORTS
//  clk          in   1       single clock, rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       level; leaves IDLE/HALTED
//  halt_req     in   1       level; stop at next instruction boundary
//  imem_req     out  1       fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc while imem_req)
//  imem_ack     in   1       fetch data valid this cycle
//  imem_data    in   16      instruction word
//  ir           out  16      latched instruction word
//  ir_valid     out  1       1-cycle pulse in DECODE
//  dec_branch   in   1       decoder: ir is a conditional jump
//  dec_halt     in   1       decoder: ir is HALT
//  dec_cond     in   5       decoder: condition code for ir
//  dec_target   in   ADDR_W  decoder: jump target for ir
//  cmp_cond     out  5       condition code to comparator
//  cmp_jump     in   1       comparator result (combinational on cmp_cond)
//  exec_done    in   1       datapath finished non-branch op
//  pc           out  ADDR_W  current program counter
//  branch_taken out  1       1-cycle pulse when a branch loads dec_target
//  halted       out  1       high in HALTED
//  retired      out  16      retired-instruction count
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, pc=RESET_PC, ir=0, retired=0, cmp_cond=0;
//    imem_req, ir_valid, branch_taken and halted all 0. Any fetch in flight is abandoned.
//  - States: IDLE, FETCH, DECODE, COMPARE, EXEC, HALTED. All outputs are registered.
//  - IDLE: start&!halt_req -> FETCH; start&halt_req -> HALTED; otherwise stay.
//  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: ir<=imem_data, go DECODE.
//    There is no timeout; an unbounded wait is legal.
//  - DECODE (1 cycle, ir_valid=1): dec_halt -> HALTED (pc unchanged, retired+1).
//    dec_branch -> COMPARE with cmp_cond<=dec_cond. Otherwise -> EXEC.
//  - COMPARE (1 cycle): sample cmp_jump. 1: pc<=dec_target and branch_taken=1 next cycle.
//    0: pc<=pc+1. retired+1.
//  - EXEC: wait for exec_done. On exec_done: pc<=pc+1, retired+1.
//  - Boundary step (COMPARE or EXEC completion): halt_req=1 -> HALTED, else -> FETCH.
//  - HALTED: halted=1. start&!halt_req -> FETCH from current pc; otherwise stay.
//  - Branch latency: DECODE->COMPARE->FETCH, so 2 cycles from ir_valid to the new imem_req.
//  - Arithmetic: pc+1 is modulo 2^ADDR_W (16'hFFFF -> 16'h0000); retired wraps at 16'hFFFF.
//  - halt_req during FETCH/DECODE/EXEC never aborts the op; it is honoured at the boundary only.
//  - exec_done outside EXEC and imem_ack outside FETCH are ignored.
//  - cmp_cond holds its last value outside COMPARE.
//  - Condition codes: 00000 EQ, 00001 NE, 00010 GT, 00011 LT, 00100 Z, 00101 NEG,
//    00110 ALL1, 01000-01011 immediate EQ/NE/GT/LT, 1xxxx ALU-zero. Undefined codes: cmp_jump=0.
// STRUCTURE
//  - Shared package cpu_ctrl_pkg holds the state encoding (3-bit localparams) and the COND_*
//    condition-code constants, which are also used by the decoder and the comparator.
//  - Single FSM plus PC/IR/retired registers; no sub-module is warranted.
// TESTING
//  1 Reset mid-FETCH (imem_req=1): assert reset_n=0 -> same cycle imem_req=0; pc=0000, state IDLE.
//  2 Taken branch: ir at pc=0004, dec_branch=1, dec_cond=00000, cmp_jump=1, dec_target=0020
//    -> cmp_cond=00000 in COMPARE, branch_taken pulse, next imem_addr=0020.
//  3 Not-taken branch at pc=0004 with cmp_jump=0 -> pc=0005, branch_taken stays 0, retired+1.
//  4 Wrap: non-branch at pc=FFFF, exec_done after 3 cycles -> pc=0000, EXEC held 3 cycles.
//  5 halt_req raised during EXEC at pc=0010 -> instruction completes, pc=0011, halted=1.
//    Then start=1 with halt_req=0 -> imem_req with imem_addr=0011.
//  6 HALT opcode at pc=0007 -> halted=1, pc=0007, retired+1; start=1 & halt_req=1 -> stays HALTED.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 16-bit CPU: the sequencer state
// encoding and the condition codes used by the sequencer, the decoder
// and the comparator.
package cpu_ctrl_pkg;

    // Sequencer state encoding (3 bits)
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_EXEC    = 3'd4;
    localparam logic [2:0] ST_HALTED  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_FETCH   = ST_FETCH,
        S_DECODE  = ST_DECODE,
        S_COMPARE = ST_COMPARE,
        S_EXEC    = ST_EXEC,
        S_HALTED  = ST_HALTED
    } seq_state_t;

    // Condition codes driven to the comparator
    localparam int COND_W = 5;

    localparam logic [COND_W-1:0] COND_EQ       = 5'b00000;
    localparam logic [COND_W-1:0] COND_NE       = 5'b00001;
    localparam logic [COND_W-1:0] COND_GT       = 5'b00010;
    localparam logic [COND_W-1:0] COND_LT       = 5'b00011;
    localparam logic [COND_W-1:0] COND_Z        = 5'b00100;
    localparam logic [COND_W-1:0] COND_NEG      = 5'b00101;
    localparam logic [COND_W-1:0] COND_ALL1     = 5'b00110;
    localparam logic [COND_W-1:0] COND_IMM_EQ   = 5'b01000;
    localparam logic [COND_W-1:0] COND_IMM_NE   = 5'b01001;
    localparam logic [COND_W-1:0] COND_IMM_GT   = 5'b01010;
    localparam logic [COND_W-1:0] COND_IMM_LT   = 5'b01011;
    // Any code with the MSB set selects the ALU-zero flag
    localparam logic [COND_W-1:0] COND_ALU_ZERO = 5'b10000;

    // True for codes the comparator evaluates; all others never jump.
    function automatic logic cond_defined(input logic [COND_W-1:0] code);
        logic ok;
        ok = 1'b0;
        if (code[4])
            ok = 1'b1;
        else if (code <= COND_ALL1)
            ok = 1'b1;
        else if ((code >= COND_IMM_EQ) && (code <= COND_IMM_LT))
            ok = 1'b1;
        return ok;
    endfunction

endpackage

// File: rtl/branch_sequencer.sv
// Instruction sequencer: owns the PC, fetches one instruction word per
// step over a req/ack handshake, resolves conditional branches through
// the external comparator, waits on multi-cycle datapath ops and handles
// start/halt. All outputs come straight from registers.
module branch_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int               ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              halt_req,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [15:0]       ir,
    output logic              ir_valid,
    input  logic              dec_branch,
    input  logic              dec_halt,
    input  logic [COND_W-1:0] dec_cond,
    input  logic [ADDR_W-1:0] dec_target,
    output logic [COND_W-1:0] cmp_cond,
    input  logic              cmp_jump,
    input  logic              exec_done,
    output logic [ADDR_W-1:0] pc,
    output logic              branch_taken,
    output logic              halted,
    output logic [15:0]       retired
);

    seq_state_t        state;
    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       retired_inc;

    // Sequential successors; both wrap naturally at their width
    assign pc_inc      = pc + ADDR_W'(1);
    assign retired_inc = retired + 16'd1;

    // pc is a register, so the fetch address is registered as well
    assign imem_addr = pc;

    // Sequencer FSM together with the PC, IR, retire counter and outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every state register uses <= so all of them update from
            // the same pre-edge values; = here would create ordering races.
            state        <= S_IDLE;
            pc           <= RESET_PC;
            ir           <= '0;
            retired      <= '0;
            cmp_cond     <= '0;
            imem_req     <= 1'b0;
            ir_valid     <= 1'b0;
            branch_taken <= 1'b0;
            halted       <= 1'b0;
        end else begin
            // Single-cycle pulses fall back to 0 unless set below
            ir_valid     <= 1'b0;
            branch_taken <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (halt_req) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
                    end
                end

                // Request stays up until the memory acknowledges
                S_FETCH: begin
                    if (imem_ack) begin
                        ir       <= imem_data;
                        imem_req <= 1'b0;
                        ir_valid <= 1'b1;
                        state    <= S_DECODE;
                    end
                end

                // Decoder outputs are combinational on ir and valid here
                S_DECODE: begin
                    if (dec_halt) begin
                        retired <= retired_inc;
                        halted  <= 1'b1;
                        state   <= S_HALTED;
                    end else if (dec_branch) begin
                        cmp_cond <= dec_cond;
                        state    <= S_COMPARE;
                    end else begin
                        state <= S_EXEC;
                    end
                end

                // cmp_cond has been stable for this cycle, so cmp_jump is settled
                S_COMPARE: begin
                    if (cmp_jump) begin
                        pc           <= dec_target;
                        branch_taken <= 1'b1;
                    end else begin
                        pc <= pc_inc;
                    end
                    retired <= retired_inc;
                    if (halt_req) begin
                        halted <= 1'b1;
                        state  <= S_HALTED;
                    end else begin
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                // Multi-cycle datapath op; halt_req only acts once it completes
                S_EXEC: begin
                    if (exec_done) begin
                        pc      <= pc_inc;
                        retired <= retired_inc;
                        if (halt_req) begin
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end

                // Resume fetching from the current pc
                S_HALTED: begin
                    if (start && !halt_req) begin
                        halted   <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule
